// File: rtl/qam_nco.sv
// Quadrature NCO: phase accumulator + quarter-wave sine ROM with symmetry folding.
// Two-stage en-qualified pipeline; sin_out/cos_out are valid when out_valid is high.
// Optional build macro QAM_NCO_DITHER_EN adds LFSR phase dither before truncation.
module qam_nco #(
    parameter int unsigned PHASE_W   = 16,
    parameter int unsigned LUT_AW    = 8,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned AMP       = 100,
    parameter int unsigned FTW_RESET = 256
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [PHASE_W-1:0]      ftw_in,
    input  logic                    ftw_load,
    input  logic [PHASE_W-1:0]      phase_off,
    input  logic                    sync,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid,
    output logic                    wrap
);

    localparam int Q  = 2 ** (LUT_AW - 2);   // quarter-wave points
    localparam int KW = LUT_AW - 2;          // index-within-quadrant width
    localparam int IW = LUT_AW - 1;          // ROM address width (0..Q)
    localparam int DW = PHASE_W - LUT_AW;    // truncated phase bits

    // Elaboration-time parameter sanity checks
    if (AMP > 2 ** (OUT_W - 1) - 1) begin : g_amp_chk
        $error("qam_nco: AMP exceeds signed OUT_W range");
    end
    if (LUT_AW < 3) begin : g_lut_chk
        $error("qam_nco: LUT_AW must be >= 3");
    end
    if (PHASE_W < LUT_AW) begin : g_phase_chk
        $error("qam_nco: PHASE_W must be >= LUT_AW");
    end

    // round-half-away(AMP * sin(pi*k/(2Q))) in 2^-28 fixed point via Taylor series
    function automatic longint rom_val(input int k);
        longint pi_fx;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        pi_fx = 64'sd843314857;
        x     = (pi_fx * longint'(k)) / longint'(2 * Q);
        x2    = (x * x) >>> 28;
        term  = x;
        sum   = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x2) >>> 28) / longint'(4 * n * n + 2 * n));
            sum  = sum + term;
        end
        scaled = sum * longint'(AMP);
        return (scaled + (64'sd1 <<< 27)) >>> 28;
    endfunction

    logic [OUT_W-1:0] rom [Q+1];

    for (genvar g = 0; g <= Q; g++) begin : g_rom
        localparam longint RomVal = rom_val(g);
        assign rom[g] = OUT_W'(RomVal);
    end

    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [PHASE_W-1:0]      ftw_q, ftw_d;
    logic [PHASE_W:0]        sum_ext;
    logic [PHASE_W-1:0]      look;
    logic [LUT_AW-1:0]       addr;
    logic                    v1_q;
    logic [LUT_AW-1:0]       a1_q;
    logic                    w1_q;
    logic signed [OUT_W-1:0] sin_q, cos_q;
    logic                    out_valid_q, wrap_q;

`ifdef QAM_NCO_DITHER_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] dith;

    // Dither LFSR next state and zero-extended dither word
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        dith = '0;
        for (int i = 0; i < int'(PHASE_W); i++) begin
            dith[i] = (i < DW) && (i < 16) ? lfsr_q[i[3:0]] : 1'b0;
        end
    end

    // LFSR register
    always_ff @(posedge Clk) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign look = phase_q + phase_off + dith;
`else
    assign look = phase_q + phase_off;
`endif

    assign sum_ext = {1'b0, phase_q} + {1'b0, ftw_q};
    assign addr    = LUT_AW'(look >> DW);

    // Accumulator and tuning-word next state; sync overrides accumulation
    always_comb begin
        phase_d = phase_q;
        if (sync) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = sum_ext[PHASE_W-1:0];
        end
        ftw_d = ftw_load ? ftw_in : ftw_q;
    end

    logic [1:0]       q_s, q_c;
    logic [KW-1:0]    k1;
    logic [IW-1:0]    idx_s, idx_c;
    logic [OUT_W-1:0] mag_s, mag_c;
    logic [OUT_W-1:0] sin_d, cos_d;

    // Quadrant folding of the stage-1 address; cosine is sine one quadrant ahead
    always_comb begin
        k1    = a1_q[KW-1:0];
        q_s   = a1_q[LUT_AW-1 -: 2];
        q_c   = q_s + 2'd1;
        idx_s = q_s[0] ? IW'(Q) - IW'(k1) : IW'(k1);
        idx_c = q_c[0] ? IW'(Q) - IW'(k1) : IW'(k1);
        mag_s = rom[idx_s];
        mag_c = rom[idx_c];
        sin_d = q_s[1] ? -mag_s : mag_s;
        cos_d = q_c[1] ? -mag_c : mag_c;
    end

    // Accumulator, stage-1 and stage-2 registers; only en cycles move the pipeline
    always_ff @(posedge Clk) begin
        if (!reset) begin
            phase_q     <= '0;
            ftw_q       <= PHASE_W'(FTW_RESET);
            v1_q        <= 1'b0;
            a1_q        <= '0;
            w1_q        <= 1'b0;
            sin_q       <= '0;
            cos_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ftw_q   <= ftw_d;
            if (en) begin
                v1_q <= 1'b1;
                a1_q <= addr;
                w1_q <= sum_ext[PHASE_W] & ~sync;
                if (v1_q) begin
                    sin_q <= sin_d;
                    cos_q <= cos_d;
                end
            end
            out_valid_q <= en & v1_q;
            wrap_q      <= en & v1_q & w1_q;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_valid_q;
    assign wrap      = wrap_q;

endmodule
